// File: rtl/adder_share_sched.sv
// Two-requester round-robin scheduler sharing one 16-bit CLA slice for 32-bit adds.
// Accept to result in 3 cycles; DONE holds its result until resp_ready, and no request is accepted meanwhile.
module adder_share_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_s,
  output logic        resp_c32,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] s_lo_q, s_lo_d;
  logic        c16_q, c16_d;
  logic [31:0] resp_s_q, resp_s_d;
  logic        resp_c32_q, resp_c32_d;
  logic        resp_id_q, resp_id_d;

  logic        grant;
  logic [15:0] slice_a, slice_b, slice_s;
  logic        slice_cin, slice_cout;

  // The slice serves the low half everywhere except HI, which chains c16.
  assign slice_a   = (state_q == HI) ? a_q[31:16] : a_q[15:0];
  assign slice_b   = (state_q == HI) ? b_q[31:16] : b_q[15:0];
  assign slice_cin = (state_q == HI) ? c16_q : 1'b0;

  cla16_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    grant = ~last_grant_q;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && (grant == 1'b0);
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && (grant == 1'b1);

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    s_lo_d       = s_lo_q;
    c16_d        = c16_q;
    resp_s_d     = resp_s_q;
    resp_c32_d   = resp_c32_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = LO;
        end
      end
      LO: begin
        s_lo_d  = slice_s;
        c16_d   = slice_cout;
        state_d = HI;
      end
      HI: begin
        resp_s_d   = {slice_s, s_lo_q};
        resp_c32_d = slice_cout;
        resp_id_d  = id_q;
        state_d    = DONE;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      s_lo_q       <= '0;
      c16_q        <= 1'b0;
      resp_s_q     <= '0;
      resp_c32_q   <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      s_lo_q       <= s_lo_d;
      c16_q        <= c16_d;
      resp_s_q     <= resp_s_d;
      resp_c32_q   <= resp_c32_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign resp_s     = resp_s_q;
  assign resp_c32   = resp_c32_q;
  assign resp_id    = resp_id_q;

endmodule

// 16-bit carry-lookahead slice: 4-bit groups with group generate/propagate.
// Purely combinational.
module cla16_slice (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g, p;
  logic [3:0]  gg, pg;
  logic [4:0]  cg;
  logic [16:0] c;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    cg[0] = cin;
    for (int k = 0; k < 4; k++) begin
      cg[k+1] = gg[k] | (pg[k] & cg[k]);
    end
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) c[i] = cg[i/4];
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    c[16] = cg[4];
    s     = p ^ c[15:0];
    cout  = cg[4];
  end

endmodule

// File: tb/tb_adder_share_sched.sv
// Directed bench for adder_share_sched with hand-computed expected values.
module tb_adder_share_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_ready, resp_id, resp_c32, busy;
  logic [31:0] resp_s;

  int vectors;
  int miscompares;
  int cnt0, cnt1;

  adder_share_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_s     (resp_s),
    .resp_c32   (resp_c32),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cnt0        = 0;
    cnt1        = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_a = 32'h0; req0_b = 32'h0;
    req1_a = 32'h0; req1_b = 32'h0;
    resp_ready = 1'b1;

    // Reset held two cycles with both requesters valid.
    tick();
    chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    tick();
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_s", resp_s, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req0_ready2", {31'b0, req0_ready}, 32'd0);

    // Release: requester 0 wins the first tie; then carry-chain operation.
    rst_n = 1'b1;
    #1;
    chk("rel_req0_ready", {31'b0, req0_ready}, 32'd1);
    chk("rel_req1_ready", {31'b0, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    req0_a = 32'h0000FFFF; req0_b = 32'h00000001;
    #1;
    chk("cc_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req0_a = 32'hDEADBEEF; req0_b = 32'hDEADBEEF;
    chk("cc_busy_lo", {31'b0, busy}, 32'd1);
    chk("cc_ready_lo", {31'b0, req0_ready}, 32'd0);
    tick();
    chk("cc_valid_hi", {31'b0, resp_valid}, 32'd0);
    tick();
    chk("cc_valid", {31'b0, resp_valid}, 32'd1);
    chk("cc_s", resp_s, 32'h00010000);
    chk("cc_c32", {31'b0, resp_c32}, 32'd0);
    chk("cc_id", {31'b0, resp_id}, 32'd0);
    tick();
    chk("cc_idle", {31'b0, busy}, 32'd0);

    // Full overflow from requester 1.
    req1_valid = 1'b1;
    req1_a = 32'hFFFFFFFF; req1_b = 32'h00000001;
    #1;
    chk("ov_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    chk("ov_valid", {31'b0, resp_valid}, 32'd1);
    chk("ov_s", resp_s, 32'h00000000);
    chk("ov_c32", {31'b0, resp_c32}, 32'd1);
    chk("ov_id", {31'b0, resp_id}, 32'd1);
    tick();

    // Both valid continuously: grants alternate 0,1,0,1.
    req0_valid = 1'b1; req0_a = 32'h00000010; req0_b = 32'h00000020;
    req1_valid = 1'b1; req1_a = 32'h80000000; req1_b = 32'h80000000;
    #1;
    for (int op = 0; op < 4; op++) begin
      chk("arb_ready0", {31'b0, req0_ready}, (op % 2 == 0) ? 32'd1 : 32'd0);
      chk("arb_ready1", {31'b0, req1_ready}, (op % 2 == 1) ? 32'd1 : 32'd0);
      cnt0 += int'(req0_ready);
      cnt1 += int'(req1_ready);
      for (int c = 0; c < 3; c++) begin
        tick();
        cnt0 += int'(req0_ready);
        cnt1 += int'(req1_ready);
      end
      chk("arb_valid", {31'b0, resp_valid}, 32'd1);
      chk("arb_id", {31'b0, resp_id}, (op % 2 == 1) ? 32'd1 : 32'd0);
      chk("arb_s", resp_s, (op % 2 == 1) ? 32'h00000000 : 32'h00000030);
      chk("arb_c32", {31'b0, resp_c32}, (op % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk("arb_pulses0", cnt0, 32'd2);
    chk("arb_pulses1", cnt1, 32'd2);

    // Back-pressure: result held for 5 cycles with resp_ready low.
    req1_valid = 1'b0;
    req0_a = 32'h12345678; req0_b = 32'h11111111;
    resp_ready = 1'b0;
    #1;
    chk("bp_req0_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h00000001; req1_b = 32'h00000002;
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_s", resp_s, 32'h23456789);
      chk("bp_c32", {31'b0, resp_c32}, 32'd0);
      chk("bp_id", {31'b0, resp_id}, 32'd0);
      chk("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      if (c < 4) tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_released", {31'b0, resp_valid}, 32'd0);
    chk("bp_idle", {31'b0, busy}, 32'd0);

    // Mid-operation reset in HI: result discarded, tie goes to requester 0.
    chk("mr_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b1;
    req0_valid = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_ready0_in_hi", {31'b0, req0_ready}, 32'd0);
    chk("mr_ready1_in_hi", {31'b0, req1_ready}, 32'd0);
    tick();
    chk("mr_valid", {31'b0, resp_valid}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_s", resp_s, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mr_tie_ready0", {31'b0, req0_ready}, 32'd1);
    chk("mr_tie_ready1", {31'b0, req1_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mr_no_stale", {31'b0, resp_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
